// File: rtl/simon_pkg.sv
// Shared Simon-game types: colour encoding, LED one-hot mapping and player FSM states.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ON    = 3'd3,
    ST_OFF   = 3'd4,
    ST_DONE  = 3'd5
  } player_state_t;

  function automatic logic [3:0] colour_to_led(input colour_t c);
    logic [3:0] led_v;
    case (c)
      RED:     led_v = 4'b0001;
      GREEN:   led_v = 4'b0010;
      BLUE:    led_v = 4'b0100;
      YELLOW:  led_v = 4'b1000;
      default: led_v = 4'b0000;
    endcase
    return led_v;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/sequence_player.sv
// Plays the first round_len colours of the sequence RAM on the LEDs with fixed on/off timing.
module sequence_player
  import simon_pkg::*;
#(
  parameter int N         = 16,
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 8,
  parameter int OFF_TICKS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   round_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS + 1);

  player_state_t     state_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W-1:0] index_r;
  logic [ADDR_W:0]   clamped_len_s;
  logic [ADDR_W:0]   next_idx_s;
  logic              tmr_load_s;
  logic              tmr_dec_s;
  logic [TIMER_W-1:0] tmr_val_s;
  logic              tmr_zero_s;

  assign clamped_len_s = (round_len > (ADDR_W+1)'(N)) ? (ADDR_W+1)'(N) : round_len;
  assign next_idx_s    = {1'b0, index_r} + (ADDR_W+1)'(1);

  // Timer control: arm ON period in LOAD, chain into OFF period when ON expires.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    tmr_val_s  = {TIMER_W{1'b0}};
    case (state_r)
      ST_LOAD: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = TIMER_W'(ON_TICKS - 1);
      end
      ST_ON: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TIMER_W'(OFF_TICKS - 1);
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_OFF: begin
        if (tmr_zero_s) begin
          tmr_dec_s = 1'b0;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .dec      (tmr_dec_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Player FSM; every output is driven from here so all of them are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      len_r   <= {(ADDR_W+1){1'b0}};
      index_r <= {ADDR_W{1'b0}};
      rd_en   <= 1'b0;
      rd_addr <= {ADDR_W{1'b0}};
      led     <= 4'b0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r   <= clamped_len_s;
            index_r <= {ADDR_W{1'b0}};
            if (clamped_len_s == {(ADDR_W+1){1'b0}}) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= {ADDR_W{1'b0}};
              state_r <= ST_FETCH;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          rd_en   <= 1'b0;
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          // rd_data is valid now, one cycle after the read strobe.
          led     <= colour_to_led(colour_t'(rd_data));
          state_r <= ST_ON;
        end
        ST_ON: begin
          if (tmr_zero_s) begin
            led     <= 4'b0000;
            state_r <= ST_OFF;
          end else begin
            state_r <= ST_ON;
          end
        end
        ST_OFF: begin
          if (tmr_zero_s) begin
            if (next_idx_s == len_r) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              index_r <= next_idx_s[ADDR_W-1:0];
              rd_addr <= next_idx_s[ADDR_W-1:0];
              rd_en   <= 1'b1;
              state_r <= ST_FETCH;
            end
          end else begin
            state_r <= ST_OFF;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          rd_en   <= 1'b0;
          led     <= 4'b0000;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench: per-cycle trace of sequence_player compared with a timing-rule reference model.
module tb_sequence_player;

  localparam int N      = 16;
  localparam int ADDR_W = 4;
  localparam int ON     = 8;
  localparam int OFF    = 4;
  localparam int P      = 2 + ON + OFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   round_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data = 2'd0;
  logic [3:0]        led;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  sequence_player #(.N(N), .ADDR_W(ADDR_W), .ON_TICKS(ON), .OFF_TICKS(OFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .round_len (round_len),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  // Registered-read RAM model
  logic [1:0] ram [N];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  typedef struct packed {
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        led;
    logic              busy;
    logic              done;
  } obs_t;

  typedef struct {
    int len;
    int fill;
    int exp_reads;
    int exp_done_at;
    bit noise;
  } vec_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic obs_t sample();
    return obs_t'({rd_en, rd_addr, led, busy, done});
  endfunction

  function automatic void fill_ram(input int mode);
    logic [1:0] base [4];
    base[0] = 2'd2; base[1] = 2'd0; base[2] = 2'd3; base[3] = 2'd1;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) ram[i] = base[i % 4];
      else if (mode == 1) ram[i] = 2'd1;
      else ram[i] = 2'($urandom_range(0, 3));
    end
  endfunction

  // Expected per-cycle trace, cycle 0 being the one right after the start edge.
  function automatic void build(input int len);
    int   eff;
    obs_t o;
    eff = (len > N) ? N : len;
    exp_q.delete();
    for (int e = 0; e < eff; e++) begin
      o = '{1'b1, ADDR_W'(e), 4'b0000, 1'b1, 1'b0};
      exp_q.push_back(o);
      o.rd_en = 1'b0;
      exp_q.push_back(o);
      o.led = 4'b0001 << ram[e];
      for (int k = 0; k < ON; k++) exp_q.push_back(o);
      o.led = 4'b0000;
      for (int k = 0; k < OFF; k++) exp_q.push_back(o);
    end
    o = '{1'b0, {ADDR_W{1'b0}}, 4'b0000, 1'b0, 1'b1};
    exp_q.push_back(o);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; issues start so it is sampled by the next posedge.
  task automatic run_play(input int len, input bit noise,
                          output int reads, output int dones, output int done_at);
    obs_t a, e;
    build(len);
    start     = 1'b1;
    round_len = 5'(len);
    @(posedge clk);
    reads = 0; dones = 0; done_at = -1;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      a = sample();
      e = exp_q[c];
      if (a.rd_en) reads++;
      if (a.done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (!e.rd_en) begin
        a.rd_addr = {ADDR_W{1'b0}};
        e.rd_addr = {ADDR_W{1'b0}};
      end
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL trace len=%0d c=%0d: got %h, expected %h", len, c, a, e);
      end
      if (noise) begin
        start     = 1'($urandom);
        round_len = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    a = sample();
    a.rd_addr = {ADDR_W{1'b0}};
    check("idle_after_done", int'(a), 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   reads, dones, done_at, len, eff;

    vecs[0] = '{3,  0, 3,  42,  1'b0};
    vecs[1] = '{0,  0, 0,  0,   1'b0};
    vecs[2] = '{20, 1, 16, 224, 1'b0};
    vecs[3] = '{3,  0, 3,  42,  1'b1};
    vecs[4] = '{1,  0, 1,  14,  1'b0};
    vecs[5] = '{16, 0, 16, 224, 1'b0};

    reset = 1'b1; start = 1'b0; round_len = 5'd0;
    fill_ram(0);
    repeat (3) @(negedge clk);
    check("reset_state", int'(sample()), 0);
    reset = 1'b0;
    @(negedge clk);

    // Table runs chain back-to-back: each start lands in the cycle after the previous done.
    for (int i = 0; i < 6; i++) begin
      fill_ram(vecs[i].fill);
      run_play(vecs[i].len, vecs[i].noise, reads, dones, done_at);
      check($sformatf("reads[%0d]", i), reads, vecs[i].exp_reads);
      check($sformatf("dones[%0d]", i), dones, 1);
      check($sformatf("done_at[%0d]", i), done_at, vecs[i].exp_done_at);
    end

    // Reset during the second ON phase
    fill_ram(0);
    start = 1'b1; round_len = 5'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    check("second_on_led", int'(led), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_led", int'(led), 0);
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_done", int'(done), 0);
    check("mid_reset_rd_en", int'(rd_en), 0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("post_reset_quiet", dones, 0);
    run_play(1, 1'b0, reads, dones, done_at);
    check("after_reset_done_at", done_at, 14);
    check("after_reset_reads", reads, 1);

    // Randomized runs against the model
    for (int r = 0; r < 6; r++) begin
      fill_ram(2);
      len = $urandom_range(0, 20);
      eff = (len > N) ? N : len;
      run_play(len, 1'b1, reads, dones, done_at);
      check($sformatf("rand_reads[%0d]", r), reads, eff);
      check($sformatf("rand_dones[%0d]", r), dones, 1);
      check($sformatf("rand_done_at[%0d]", r), done_at, eff * P);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
